shift_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-bit logical-left barrel-shift stage among four requesters. Each requester presents an operand and a shift amount with a valid/ready handshake. The block selects one winner per cycle, shifts its operand, and holds the result in a single registered output slot tagged with the winner's index. It sits between the requester-side control logic and the downstream consumer of shift results.

---
 rtl/shift_pkg.sv | 15 +
 rtl/shift_arbiter_if.sv | 24 ++
 rtl/shift_arbiter_rr_pick4.sv | 31 +++
 rtl/shift_arbiter.sv | 62 ++++++
 tb/tb_shift_arbiter.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared constants and shift helper for the
// shift arbiter and other shift users.
package shift_pkg;
   localparam int N_REQ = 4;
   localparam int WIDTH = 8;
   localparam int SHW   = 3;
   localparam int ID_W  = 2;

   function automatic logic [WIDTH-1:0] lsl(
      input logic [WIDTH-1:0] data,
      input logic [SHW-1:0]   amt
   );
      return data << amt;
   endfunction
endpackage

// File: rtl/shift_arbiter_if.sv
// Requester and result-slot handshake bundle
// for the shift arbiter.
interface shift_arbiter_if;
   import shift_pkg::*;

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*WIDTH-1:0] req_data;
   logic [N_REQ*SHW-1:0]   req_amt;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       out_data;
   logic [ID_W-1:0]        out_id;

   modport master (
      output req_valid, req_data, req_amt, out_ready,
      input  req_ready, out_valid, out_data, out_id
   );

   modport slave (
      input  req_valid, req_data, req_amt, out_ready,
      output req_ready, out_valid, out_data, out_id
   );
endinterface

// File: rtl/shift_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker:
// first valid at or above ptr, with wrap.
module rr_pick4
   import shift_pkg::*;
(
   input  logic [N_REQ-1:0] valid,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  idx,
   output logic             any_valid
);

   logic [ID_W-1:0] cand;
   logic            found;

   always_comb begin
      cand  = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = ptr + ID_W'(k);
         if (!found && valid[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      grant     = found ? (N_REQ'(1) << idx) : '0;
      any_valid = found;
   end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin share of one barrel shifter among
// four requesters, with a single output slot.
module shift_arbiter
   import shift_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   shift_arbiter_if.slave  bus,
   output logic            busy
);

   logic [ID_W-1:0]  ptr;
   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  idx;
   logic             any_valid;
   logic             slot_free;
   logic             xfer;
   logic             vld;
   logic [WIDTH-1:0] dat;
   logic [ID_W-1:0]  id;
   logic [WIDTH-1:0] sel_data;
   logic [SHW-1:0]   sel_amt;

   rr_pick4 u_pick (
      .valid     (bus.req_valid),
      .ptr       (ptr),
      .grant     (grant),
      .idx       (idx),
      .any_valid (any_valid)
   );

   assign slot_free     = !vld || bus.out_ready;
   assign xfer          = any_valid && slot_free;
   assign bus.req_ready = slot_free ? grant : '0;

   assign sel_data = bus.req_data[idx*WIDTH +: WIDTH];
   assign sel_amt  = bus.req_amt[idx*SHW +: SHW];

   // Reload takes priority over drain so the slot
   // sustains one result per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= 1'b0;
         dat <= '0;
         id  <= '0;
         ptr <= '0;
      end else if (xfer) begin
         vld <= 1'b1;
         dat <= lsl(sel_data, sel_amt);
         id  <= idx;
         ptr <= idx + ID_W'(1);
      end else if (bus.out_ready) begin
         vld <= 1'b0;
      end
   end

   assign bus.out_valid = vld;
   assign bus.out_data  = dat;
   assign bus.out_id    = id;
   assign busy          = vld || (|bus.req_valid);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter.
// Inputs change just after posedge; outputs sampled at negedge.
module tb_shift_arbiter;
   import shift_pkg::*;

   logic clk;
   logic rst_n;
   logic busy;
   int   checks;
   int   errors;

   shift_arbiter_if bus ();

   shift_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(
      input int         i,
      input logic [7:0] d,
      input logic [2:0] a
   );
      bus.req_data[i*WIDTH +: WIDTH] = d;
      bus.req_amt[i*SHW +: SHW]      = a;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Single request from requester 2; ends at a negedge
   task automatic single(
      input logic [7:0] d,
      input logic [2:0] a,
      input logic [7:0] exp
   );
      set_req(2, d, a);
      bus.req_valid = 4'b0100;
      #1;
      check("single_rdy", 32'(bus.req_ready), 32'h4);
      @(posedge clk);
      #1;
      bus.req_valid = 4'b0000;
      @(negedge clk);
      check("single_vld", 32'(bus.out_valid), 32'h1);
      check("single_dat", 32'(bus.out_data), 32'(exp));
      check("single_id", 32'(bus.out_id), 32'h2);
   endtask

   initial begin
      logic [7:0] d;
      logic [1:0] e;
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_amt   = '0;
      bus.out_ready = 1'b0;

      // reset / idle
      do_reset();
      check("rst_vld", 32'(bus.out_valid), 32'h0);
      check("rst_dat", 32'(bus.out_data), 32'h0);
      check("rst_rdy", 32'(bus.req_ready), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);

      // single requests with shift boundaries
      bus.out_ready = 1'b1;
      single(8'h80, 3'd3, 8'h00);
      single(8'h01, 3'd4, 8'h10);
      single(8'hFF, 3'd7, 8'h80);
      single(8'h5A, 3'd0, 8'h5A);
      single(8'h80, 3'd1, 8'h00);
      @(negedge clk);
      check("drain_vld", 32'(bus.out_valid), 32'h0);
      check("drain_dat", 32'(bus.out_data), 32'h0);

      // round robin, all requesters valid
      do_reset();
      for (int i = 0; i < N_REQ; i++)
         set_req(i, 8'(8'h11 * (i + 1)), 3'd0);
      set_req(3, 8'h44, 3'd1);
      bus.req_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         e = 2'(k % 4);
         d = (e == 2'd3) ? 8'h88 : 8'(8'h11 * (e + 1));
         check("rr_vld", 32'(bus.out_valid), 32'h1);
         check("rr_id", 32'(bus.out_id), 32'(e));
         check("rr_dat", 32'(bus.out_data), 32'(d));
      end

      // backpressure holds the slot
      bus.out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_vld", 32'(bus.out_valid), 32'h1);
         check("bp_id", 32'(bus.out_id), 32'h0);
         check("bp_dat", 32'(bus.out_data), 32'h11);
         check("bp_rdy", 32'(bus.req_ready), 32'h0);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_rdy", 32'(bus.req_ready), 32'h2);
      @(negedge clk);
      check("bp_release_id", 32'(bus.out_id), 32'h1);
      check("bp_release_dat", 32'(bus.out_data), 32'h22);

      // only 1 and 3 valid, ptr now 2
      bus.req_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         e = (k % 2 == 0) ? 2'd3 : 2'd1;
         d = (e == 2'd3) ? 8'h88 : 8'h22;
         check("skip_id", 32'(bus.out_id), 32'(e));
         check("skip_dat", 32'(bus.out_data), 32'(d));
      end

      // async reset while full and stalled
      bus.out_ready = 1'b0;
      bus.req_valid = 4'b0000;
      @(negedge clk);
      check("pre_rst_vld", 32'(bus.out_valid), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_vld", 32'(bus.out_valid), 32'h0);
      check("async_dat", 32'(bus.out_data), 32'h0);
      bus.req_valid = 4'hF;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("rst_no_xfer", 32'(bus.out_valid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_rdy", 32'(bus.req_ready), 32'h1);
      @(negedge clk);
      check("post_rst_id", 32'(bus.out_id), 32'h0);
      check("post_rst_dat", 32'(bus.out_data), 32'h11);
      check("post_rst_busy", 32'(busy), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
